poly_eval_horner: RTL

//  Parametrised polynomial evaluator: y = c[N]*x^N + ... + c[1]*x + c[0] mod 2^DATA_W, N = DEGREE.

---
 rtl/poly_eval_horner.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/poly_eval_horner.sv
// Streaming Horner-rule polynomial evaluator: loads DEGREE+1 coefficients (highest first), then x, then does one multiply-add per clock.
// Optional sticky overflow flag out_ovf is built when the POLY_OVF_FLAG_EN macro is defined.
module poly_eval_horner #(
    parameter int DATA_W = 8,
    parameter int DEGREE = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              keep_coef,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
`ifdef POLY_OVF_FLAG_EN
    output logic              out_ovf,
`endif
    input  logic              out_ready
);

    localparam int IDX_W  = $clog2(DEGREE + 1);
    localparam int FULL_W = 2 * DATA_W + 1;

    typedef enum logic [1:0] {
        S_LOAD_COEF = 2'd0,
        S_LOAD_X    = 2'd1,
        S_CALC      = 2'd2,
        S_DONE      = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   step_q, step_d;
    logic [DATA_W-1:0]  acc_q, acc_d;
    logic [DATA_W-1:0]  x_q, x_d;
    logic [DATA_W-1:0]  out_data_q, out_data_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [DATA_W-1:0]  coef_q [0:DEGREE];
    logic               coef_we_s;
    logic [IDX_W-1:0]   coef_sel_s;
    logic               in_fire_s;
    logic               out_fire_s;
    logic [FULL_W-1:0]  full_s;

    // One Horner step at full precision so the carry-out is visible before truncation.
    function automatic logic [FULL_W-1:0] mac_full(input logic [DATA_W-1:0] acc,
                                                   input logic [DATA_W-1:0] x,
                                                   input logic [DATA_W-1:0] c);
        logic [FULL_W-1:0] a_w;
        logic [FULL_W-1:0] x_w;
        logic [FULL_W-1:0] c_w;
        a_w = {{(DATA_W + 1){1'b0}}, acc};
        x_w = {{(DATA_W + 1){1'b0}}, x};
        c_w = {{(DATA_W + 1){1'b0}}, c};
        return (a_w * x_w) + c_w;
    endfunction

    assign in_fire_s  = in_valid & in_ready_q;
    assign out_fire_s = out_valid_q & out_ready;
    assign coef_sel_s = IDX_W'(DEGREE) - idx_q;
    assign full_s     = mac_full(acc_q, x_q, coef_q[step_q]);

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;

    // Next-state and datapath control for the load/calc/done sequence.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        step_d     = step_q;
        acc_d      = acc_q;
        x_d        = x_q;
        out_data_d = out_data_q;
        coef_we_s  = 1'b0;
        case (state_q)
            S_LOAD_COEF: begin
                if (in_fire_s) begin
                    coef_we_s = 1'b1;
                    if (idx_q == IDX_W'(DEGREE)) begin
                        idx_d   = IDX_W'(0);
                        state_d = S_LOAD_X;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    idx_d = idx_q;
                end
            end
            S_LOAD_X: begin
                if (in_fire_s) begin
                    x_d     = in_data;
                    acc_d   = coef_q[DEGREE];
                    step_d  = IDX_W'(DEGREE - 1);
                    state_d = S_CALC;
                end else begin
                    x_d = x_q;
                end
            end
            S_CALC: begin
                acc_d = full_s[DATA_W-1:0];
                if (step_q == IDX_W'(0)) begin
                    out_data_d = full_s[DATA_W-1:0];
                    state_d    = S_DONE;
                end else begin
                    step_d = step_q - IDX_W'(1);
                end
            end
            S_DONE: begin
                if (out_fire_s) begin
                    if (keep_coef) begin
                        state_d = S_LOAD_X;
                    end else begin
                        state_d = S_LOAD_COEF;
                        idx_d   = IDX_W'(0);
                    end
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_LOAD_COEF;
                idx_d   = IDX_W'(0);
            end
        endcase
        in_ready_d  = (state_d == S_LOAD_COEF) || (state_d == S_LOAD_X);
        out_valid_d = (state_d == S_DONE);
    end

    // Control and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_LOAD_COEF;
            idx_q       <= IDX_W'(0);
            step_q      <= IDX_W'(0);
            acc_q       <= '0;
            x_q         <= '0;
            out_data_q  <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            step_q      <= step_d;
            acc_q       <= acc_d;
            x_q         <= x_d;
            out_data_q  <= out_data_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Coefficient file; word k of a load lands in slot DEGREE-k.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i <= DEGREE; i++) begin
                coef_q[i] <= '0;
            end
        end else if (coef_we_s) begin
            coef_q[coef_sel_s] <= in_data;
        end
    end

`ifdef POLY_OVF_FLAG_EN
    logic ovf_q, ovf_d;

    // Sticky carry-out flag, cleared as a new evaluation starts.
    always_comb begin
        ovf_d = ovf_q;
        if ((state_q == S_LOAD_X) && in_fire_s) begin
            ovf_d = 1'b0;
        end else if (state_q == S_CALC) begin
            ovf_d = ovf_q | (|full_s[FULL_W-1:DATA_W]);
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Overflow flag register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign out_ovf = ovf_q;
`else
    logic unused_carry_s;
    assign unused_carry_s = ^full_s[FULL_W-1:DATA_W];
`endif

endmodule
